// File: rtl/divide_sequencer_32_pkg.sv
// Shared constants for the 32-bit signed divide sequencer: state encodings,
// datapath width and the iteration counter geometry.
package divide_sequencer_32_pkg;

  localparam int DW    = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/adder_32.sv
// Plain 32-bit adder with carry-in; callers derive any carry-out they need
// from the sum and operand MSBs.
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  assign sum = a + b + {31'd0, cin};

endmodule

// File: rtl/divider_32.sv
// Restoring signed divider: magnitudes are divided one bit per enabled edge,
// quotient sign is applied combinationally from the operand inputs.
module divider_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] a_mag, b_mag, quo, shifted, diff, b_inv;
  logic [30:0] rem;
  logic        c31, no_borrow;

  assign a_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign b_mag = divisor[31]  ? (~divisor  + 32'd1) : divisor;
  assign b_inv = ~b_mag;

  // rem stays below |divisor| <= 2^31, so 31 bits hold it and the shift fits 32
  assign shifted = {rem, quo[31]};

  adder_32 u_sub (
    .a   (shifted),
    .b   (b_inv),
    .cin (1'b1),
    .sum (diff)
  );

  // carry out of the MSB: set when shifted >= |divisor|
  assign c31       = diff[31] ^ shifted[31] ^ b_inv[31];
  assign no_borrow = (shifted[31] & b_inv[31]) | ((shifted[31] ^ b_inv[31]) & c31);

  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      quo <= a_mag;
    end else if (en) begin
      rem <= no_borrow ? diff[30:0] : shifted[30:0];
      quo <= {quo[30:0], no_borrow};
    end
  end

  assign quotient  = (dividend[31] ^ divisor[31]) ? (~quo + 32'd1) : quo;
  assign remainder = {1'b0, rem};

endmodule

// File: rtl/divide_sequencer_32.sv
// Sequencer around divider_32: accepts an operation, runs 32 iterations,
// fixes the remainder sign and presents results with a done pulse.
module divide_sequencer_32
  import divide_sequencer_32_pkg::*;
(
  input  logic          clk,
  input  logic          in_reset,
  input  logic          in_start,
  input  logic          in_abort,
  input  logic [DW-1:0] in_dividend,
  input  logic [DW-1:0] in_divisor,
  output logic          out_busy,
  output logic          out_done,
  output logic          out_div_zero,
  output logic [DW-1:0] out_lo,
  output logic [DW-1:0] out_hi
);

  state_e           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    op_a, op_b, div_q, rem_mag, rem_neg;
  logic             load, accept, zero_div;

  assign load     = (state == ST_LOAD);
  assign accept   = (state == ST_IDLE) && in_start;
  assign zero_div = (in_divisor == '0);

  divider_32 u_div (
    .clk       (clk),
    .reset     (load),
    .en        (state == ST_RUN),
    .dividend  (op_a),
    .divisor   (op_b),
    .quotient  (div_q),
    .remainder (rem_mag)
  );

  adder_32 u_neg (
    .a   (~rem_mag),
    .b   ('0),
    .cin (1'b1),
    .sum (rem_neg)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (in_start) next_state = zero_div ? ST_DONE : ST_LOAD;
      ST_LOAD: next_state = in_abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (in_abort)              next_state = ST_IDLE;
        else if (cnt == LAST_CNT)  next_state = ST_FIX;
      end
      ST_FIX:  next_state = in_abort ? ST_IDLE : ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      state <= next_state;
      if (load)                cnt <= '0;
      else if (state == ST_RUN) cnt <= cnt + 1'b1;
      // operands stay put until the next accept: the quotient sign reads them live
      if (accept) begin
        op_a <= in_dividend;
        op_b <= in_divisor;
      end
    end
  end

  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) begin
      out_lo       <= '0;
      out_hi       <= '0;
      out_div_zero <= 1'b0;
      out_done     <= 1'b0;
    end else begin
      out_done <= (state == ST_DONE);
      if (accept && zero_div) begin
        out_lo       <= '1;
        out_hi       <= in_dividend;
        out_div_zero <= 1'b1;
      end else if (accept) begin
        out_div_zero <= 1'b0;
      end else if (state == ST_FIX && !in_abort) begin
        out_lo <= div_q;
        out_hi <= op_a[DW-1] ? rem_neg : rem_mag;
      end
    end
  end

  assign out_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_divide_sequencer_32.sv
// Scoreboard bench for divide_sequencer_32: directed scenarios plus random
// operands checked against truncating signed division on 64-bit integers.
module tb_divide_sequencer_32;

  logic        clk = 1'b0;
  logic        in_reset, in_start, in_abort;
  logic [31:0] in_dividend, in_divisor;
  logic        out_busy, out_done, out_div_zero;
  logic [31:0] out_lo, out_hi;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0, cyc = 0;
  logic [31:0] last_lo = '0, last_hi = '0;
  logic        last_dz = 1'b0;

  divide_sequencer_32 dut (
    .clk          (clk),
    .in_reset     (in_reset),
    .in_start     (in_start),
    .in_abort     (in_abort),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_div_zero (out_div_zero),
    .out_lo       (out_lo),
    .out_hi       (out_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int c0);
    exp_t   e;
    longint sa, sb_, q, r;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1; e.due = c0 + 2;
    end else begin
      sa = $signed(a); sb_ = $signed(b);
      q = sa / sb_; r = sa % sb_;
      e.lo = q[31:0]; e.hi = r[31:0]; e.dz = 1'b0; e.due = c0 + 36;
    end
    return e;
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!in_reset && out_done) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("lo", {32'd0, out_lo}, {32'd0, e.lo});
        chk("hi", {32'd0, out_hi}, {32'd0, e.hi});
        chk("div_zero", {63'd0, out_div_zero}, {63'd0, e.dz});
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // drive a start at the current negedge; optionally record the expected result
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit expect_it);
    exp_t e;
    in_start = 1'b1; in_dividend = a; in_divisor = b;
    if (expect_it) begin
      e = model(a, b, cyc);
      sb.push_back(e);
      last_lo = e.lo; last_hi = e.hi; last_dz = e.dz;
    end
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !out_busy) return;
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL wait_idle: got still busy expected idle within 200 cycles");
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_op(a, b, 1'b1);
    wait_idle();
  endtask

  initial begin
    in_reset = 1'b1; in_start = 1'b0; in_abort = 1'b0;
    in_dividend = '0; in_divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, out_busy}, 64'd0);
    chk("rst_done", {63'd0, out_done}, 64'd0);
    chk("rst_dz", {63'd0, out_div_zero}, 64'd0);
    chk("rst_lo", {32'd0, out_lo}, 64'd0);
    chk("rst_hi", {32'd0, out_hi}, 64'd0);
    in_reset = 1'b0;

    run_op(32'd30, 32'd4);
    run_op(32'd10, 32'hFFFF_FFFD);
    run_op(32'hFFFF_FE0C, 32'd3);
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF7);
    run_op(32'd123, 32'd0);
    run_op(32'd30, 32'd4);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'h8000_0000, 32'h8000_0000);
    run_op(32'h7FFF_FFFF, 32'h8000_0000);
    run_op(32'd0, 32'hFFFF_FFFF);

    // second start during RUN is ignored
    @(negedge clk);
    start_op(32'd30, 32'd4, 1'b1);
    repeat (9) @(negedge clk);
    chk("busy_in_run", {63'd0, out_busy}, 64'd1);
    start_op(32'd100, 32'd5, 1'b0);
    wait_idle();
    repeat (5) @(negedge clk);

    // start wins over abort in IDLE
    @(negedge clk);
    in_abort = 1'b1;
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    in_abort = 1'b0;
    wait_idle();

    // abort at RUN counter 10: nothing written, no done
    @(negedge clk);
    start_op(32'd999, 32'd7, 1'b0);
    repeat (11) @(negedge clk);
    in_abort = 1'b1;
    @(negedge clk);
    in_abort = 1'b0;
    chk("abort_busy", {63'd0, out_busy}, 64'd0);
    chk("abort_lo", {32'd0, out_lo}, {32'd0, last_lo});
    chk("abort_hi", {32'd0, out_hi}, {32'd0, last_hi});
    chk("abort_dz", {63'd0, out_div_zero}, {63'd0, last_dz});
    repeat (40) @(negedge clk);

    // reset at RUN counter 10: everything cleared, no done after release
    start_op(32'd555, 32'd11, 1'b0);
    repeat (11) @(negedge clk);
    in_reset = 1'b1;
    #1;
    chk("reset_busy", {63'd0, out_busy}, 64'd0);
    @(negedge clk);
    chk("reset_lo", {32'd0, out_lo}, 64'd0);
    chk("reset_hi", {32'd0, out_hi}, 64'd0);
    chk("reset_dz", {63'd0, out_div_zero}, 64'd0);
    in_reset = 1'b0;
    last_lo = '0; last_hi = '0; last_dz = 1'b0;
    repeat (40) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($signed($urandom_range(1, 20)) * (($urandom_range(0, 1) == 0) ? 1 : -1));
        default: b = $urandom;
      endcase
      run_op(a, b);
    end

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL pending: got %0d outstanding results expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
